// File: rtl/phase_seq_pkg.sv
// -----------------------------------------------------------------------------
// phase_seq_pkg
// Shared definitions for the instruction phase sequencer:
//   - state_t   : one-hot state encoding of the sequencer FSM
//   - OP_*      : opcode values and don't-care masks (a 0 mask bit is "x")
//   - is_stop() / is_two_phase() : opcode classification helpers
// Any opcode that is neither stop nor two-phase is a single-phase opcode.
// -----------------------------------------------------------------------------
package phase_seq_pkg;

    localparam int OP_W = 5;

    typedef enum logic [4:0] {
        S_HALT   = 5'b00001,
        S_FETCH  = 5'b00010,
        S_EXEC1  = 5'b00100,
        S_EXEC2  = 5'b01000,
        S_PAUSED = 5'b10000
    } state_t;

    localparam logic [OP_W-1:0] OP_STP      = 5'b00000;
    localparam logic [OP_W-1:0] OP_STP_MASK = 5'b11111;
    localparam logic [OP_W-1:0] OP_ADM      = 5'b00010;   // 0001x
    localparam logic [OP_W-1:0] OP_ADM_MASK = 5'b11110;
    localparam logic [OP_W-1:0] OP_SBM      = 5'b00110;   // 0011x
    localparam logic [OP_W-1:0] OP_SBM_MASK = 5'b11110;
    localparam logic [OP_W-1:0] OP_LDR      = 5'b01110;
    localparam logic [OP_W-1:0] OP_LDR_MASK = 5'b11111;
    localparam logic [OP_W-1:0] OP_LDA      = 5'b11000;   // 110xx
    localparam logic [OP_W-1:0] OP_LDA_MASK = 5'b11100;

    function automatic logic op_match(input logic [OP_W-1:0] op,
                                      input logic [OP_W-1:0] val,
                                      input logic [OP_W-1:0] mask);
        return (op & mask) == (val & mask);
    endfunction

    function automatic logic is_stop(input logic [OP_W-1:0] op);
        return op_match(op, OP_STP, OP_STP_MASK);
    endfunction

    function automatic logic is_two_phase(input logic [OP_W-1:0] op);
        return op_match(op, OP_ADM, OP_ADM_MASK) |
               op_match(op, OP_SBM, OP_SBM_MASK) |
               op_match(op, OP_LDR, OP_LDR_MASK) |
               op_match(op, OP_LDA, OP_LDA_MASK);
    endfunction

endpackage

// File: rtl/phase_perf_cnt.sv
// -----------------------------------------------------------------------------
// phase_perf_cnt
// Performance counters for the phase sequencer. Both counters wrap modulo
// 2^CNT_W and hold whenever their increment condition is low.
// Ports:
//   clk, rst_n  : core clock, asynchronous active-low reset
//   active      : sequencer is in a fetch or execute phase this cycle
//   instr_done  : last execute phase of a completed instruction
//   cycle_cnt   : number of active cycles
//   instr_cnt   : number of completed instructions
// -----------------------------------------------------------------------------
module phase_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             instr_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (active)     cycle_cnt <= cycle_cnt + 1'b1;
            if (instr_done) instr_cnt <= instr_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
// Drives the fetch / execute phase strobes for the 16-bit core. Each
// instruction is fetched (fe), then executed in one (e1) or two (e1, e2)
// phases depending on its opcode; the stop opcode halts the core. Pause and
// single-step requests are honoured only at instruction boundaries.
// Ports:
//   clk, rst_n  : core clock (rising edge), asynchronous active-low reset
//   instr_op    : opcode field of the fetched instruction, valid in EXEC1
//   start       : pulse, leaves HALT
//   pause_req   : level, pause at the next instruction boundary
//   step_mode   : level, pause after every instruction
//   step        : pulse, releases one instruction from PAUSED in step mode
//   fe, e1, e2  : phase strobes (fetch, execute 1, execute 2)
//   halted      : in HALT
//   paused      : in PAUSED
//   instr_done  : last execute phase of a non-stop instruction
// Optional build macro PHASE_SEQ_PERF_CNT_EN adds cycle_cnt / instr_cnt.
// -----------------------------------------------------------------------------
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter bit START_RUNNING = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] instr_op,
    input  logic            start,
    input  logic            pause_req,
    input  logic            step_mode,
    input  logic            step,
    output logic            fe,
    output logic            e1,
    output logic            e2,
    output logic            halted,
    output logic            paused,
    output logic            instr_done
`ifdef PHASE_SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    localparam state_t RESET_STATE = START_RUNNING ? S_FETCH : S_HALT;

    state_t state_q;
    state_t state_d;
    state_t boundary_state;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RESET_STATE;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        boundary_state = (pause_req | step_mode) ? S_PAUSED : S_FETCH;
        state_d        = state_q;
        unique case (state_q)
            S_HALT:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_EXEC1;
            S_EXEC1: begin
                if (is_stop(instr_op))           state_d = S_HALT;
                else if (is_two_phase(instr_op)) state_d = S_EXEC2;
                else                             state_d = boundary_state;
            end
            S_EXEC2:  state_d = boundary_state;
            S_PAUSED: if (!pause_req && (!step_mode || step)) state_d = S_FETCH;
            default:  state_d = S_HALT;   // illegal one-hot code: park safely
        endcase
    end

    // ---------------- output decode ----------------
    // The reset state for START_RUNNING=1 is FETCH, but no strobe may be
    // shown while reset is held, so the strobes are qualified by rst_n.
    // halted is left unqualified so it reads !START_RUNNING during reset.
    always_comb begin
        fe         = rst_n && (state_q == S_FETCH);
        e1         = rst_n && (state_q == S_EXEC1);
        e2         = rst_n && (state_q == S_EXEC2);
        paused     = rst_n && (state_q == S_PAUSED);
        halted     = (state_q == S_HALT);
        instr_done = e2 || (e1 && !is_stop(instr_op) && !is_two_phase(instr_op));
    end

`ifdef PHASE_SEQ_PERF_CNT_EN
    phase_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .active     (fe | e1 | e2),
        .instr_done (instr_done),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );
`else
    // Counters are not built; CNT_W is kept so the parameter list is the
    // same in both builds.
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule
